// File: rtl/dru_bit_gearbox_if.sv
// Bit-stream bus between the DRU sample output and the word gearbox.
// The master drives samples and slip commands; the slave returns packed words and status.
interface dru_bit_gearbox_if #(
  parameter int S_MAX  = 10,
  parameter int WORD_W = 20
);
  localparam int BUF_W = WORD_W + S_MAX;
  localparam int CNT_W = $clog2(BUF_W + 1);

  // Streaming contract: there is no ready. The gearbox accepts every cycle in which
  // en=1 and samv<=S_MAX. dout_vld is a one-cycle qualifier for dout, and the
  // consumer must take the word in that cycle.
  logic              en;
  logic [3:0]        samv;
  logic [S_MAX-1:0]  sam;
  logic              slip;
  logic [WORD_W-1:0] dout;
  logic              dout_vld;
  logic [CNT_W-1:0]  fill;
  logic              slip_busy;
  logic              err_samv;

  modport master (
    output en, samv, sam, slip,
    input  dout, dout_vld, fill, slip_busy, err_samv
  );

  modport slave (
    input  en, samv, sam, slip,
    output dout, dout_vld, fill, slip_busy, err_samv
  );
endinterface

// File: rtl/dru_bit_gearbox.sv
// Packs the variable-rate DRU bit stream (0..S_MAX bits per clock) into WORD_W-bit words.
// A one-bit slip drops the oldest buffered bit so the downstream aligner can move the word boundary.
module dru_bit_gearbox #(
  parameter int S_MAX  = 10,
  parameter int WORD_W = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  dru_bit_gearbox_if.slave bus
);
  localparam int BUF_W = WORD_W + S_MAX;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [3:0]       SMAX_V = 4'(S_MAX);
  localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic {
    SLIP_IDLE = 1'b0,
    SLIP_PEND = 1'b1
  } slip_state_e;

  // Invariant: buf_q bits at and above cnt_q are always zero, so appends can simply OR in.
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  slip_state_e       slip_st_q, slip_st_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;

  logic              samv_ok;
  logic              append;
  logic              slip_req;
  logic [S_MAX-1:0]  sam_masked;
  logic [BUF_W-1:0]  buf_a, buf_s;
  logic [CNT_W-1:0]  cnt_a, cnt_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q     <= '0;
      cnt_q     <= '0;
      slip_st_q <= SLIP_IDLE;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      slip_st_q <= slip_st_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    samv_ok    = (bus.samv <= SMAX_V);
    append     = bus.en && samv_ok;
    sam_masked = '0;
    for (int i = 0; i < S_MAX; i++) begin
      if (i < int'(bus.samv)) sam_masked[i] = bus.sam[i];
    end

    buf_a = buf_q;
    cnt_a = cnt_q;
    if (append) begin
      buf_a = buf_q | (BUF_W'(sam_masked) << cnt_q);
      cnt_a = cnt_q + CNT_W'(bus.samv);
    end

    // A slip that arrives while the buffer is empty waits for the next bit to drop.
    slip_req  = bus.slip || (slip_st_q == SLIP_PEND);
    slip_st_d = slip_st_q;
    buf_s     = buf_a;
    cnt_s     = cnt_a;
    if (slip_req) begin
      if (cnt_a != '0) begin
        buf_s     = buf_a >> 1;
        cnt_s     = cnt_a - ONE_C;
        slip_st_d = SLIP_IDLE;
      end else begin
        slip_st_d = SLIP_PEND;
      end
    end

    buf_d  = buf_s;
    cnt_d  = cnt_s;
    dout_d = dout_q;
    vld_d  = 1'b0;
    if (cnt_s >= WORD_C) begin
      dout_d = buf_s[WORD_W-1:0];
      vld_d  = 1'b1;
      buf_d  = buf_s >> WORD_W;
      cnt_d  = cnt_s - WORD_C;
    end

    err_d = err_q || (bus.en && !samv_ok);
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.fill      = cnt_q;
  assign bus.slip_busy = (slip_st_q == SLIP_PEND);
  assign bus.err_samv  = err_q;
endmodule

// File: tb/tb_dru_bit_gearbox.sv
// Directed bench for dru_bit_gearbox: packing, carry-over, illegal counts, slips and reset.
module tb_dru_bit_gearbox;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dru_bit_gearbox_if #(.S_MAX(10), .WORD_W(20)) bus ();

  dru_bit_gearbox #(.S_MAX(10), .WORD_W(20)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs for one edge, then settle 1ns past it for sampling
  task automatic step(input logic r, input logic en, input logic [3:0] samv,
                      input logic [9:0] sam, input logic slip);
    rst      = r;
    bus.en   = en;
    bus.samv = samv;
    bus.sam  = sam;
    bus.slip = slip;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.samv = '0;
    bus.sam  = '0;
    bus.slip = 1'b0;

    // reset state
    step(1, 0, 0, 10'h000, 0);
    check("rst_fill", 32'(bus.fill), 0);
    check("rst_dout", 32'(bus.dout), 0);
    check("rst_vld", 32'(bus.dout_vld), 0);
    check("rst_busy", 32'(bus.slip_busy), 0);
    check("rst_err", 32'(bus.err_samv), 0);

    // basic packing
    step(0, 1, 10, 10'h3FF, 0);
    check("t1_fill10", 32'(bus.fill), 10);
    check("t1_vld0", 32'(bus.dout_vld), 0);
    step(0, 1, 10, 10'h000, 0);
    check("t1_dout", 32'(bus.dout), 32'h003FF);
    check("t1_vld1", 32'(bus.dout_vld), 1);
    check("t1_fill0", 32'(bus.fill), 0);
    step(0, 1, 0, 10'h3FF, 0);
    check("t1_vld_once", 32'(bus.dout_vld), 0);

    // carry-over
    step(0, 1, 9, 10'h1FF, 0);
    check("t2_fill9", 32'(bus.fill), 9);
    step(0, 1, 9, 10'h1FF, 0);
    check("t2_fill18", 32'(bus.fill), 18);
    step(0, 1, 9, 10'h1FF, 0);
    check("t2_fill7", 32'(bus.fill), 7);
    check("t2_dout", 32'(bus.dout), 32'hFFFFF);
    check("t2_vld1", 32'(bus.dout_vld), 1);
    step(0, 1, 0, 10'h000, 0);
    check("t2_vld0", 32'(bus.dout_vld), 0);
    check("t2_hold", 32'(bus.dout), 32'hFFFFF);
    check("t2_fill_hold", 32'(bus.fill), 7);

    // illegal count: ERR_SAMV sticky, nothing appended
    step(1, 0, 0, 10'h000, 0);
    step(0, 1, 5, 10'h015, 0);
    check("t3_fill5", 32'(bus.fill), 5);
    step(0, 1, 12, 10'h3FF, 0);
    check("t3_err", 32'(bus.err_samv), 1);
    check("t3_fill_keep", 32'(bus.fill), 5);
    check("t3_vld0", 32'(bus.dout_vld), 0);
    step(0, 1, 10, 10'h3FF, 0);
    check("t3_fill15", 32'(bus.fill), 15);
    step(0, 1, 5, 10'h01F, 0);
    check("t3_dout", 32'(bus.dout), 32'hFFFF5);
    check("t3_vld1", 32'(bus.dout_vld), 1);
    check("t3_err_sticky", 32'(bus.err_samv), 1);

    // deferred slip; the pending slip drops the single 1 at bit 0, leaving 9 zeros
    step(1, 0, 0, 10'h000, 0);
    step(0, 0, 0, 10'h000, 1);
    check("t4_busy1", 32'(bus.slip_busy), 1);
    check("t4_fill0", 32'(bus.fill), 0);
    step(0, 1, 10, 10'h001, 0);
    check("t4_fill9", 32'(bus.fill), 9);
    check("t4_busy0", 32'(bus.slip_busy), 0);
    step(0, 1, 10, 10'h3FF, 0);
    check("t4_fill19", 32'(bus.fill), 19);
    step(0, 1, 1, 10'h001, 0);
    check("t4_dout", 32'(bus.dout), 32'hFFE00);
    check("t4_vld1", 32'(bus.dout_vld), 1);
    check("t4_fill0b", 32'(bus.fill), 0);

    // slip does not stack while pending
    step(1, 0, 0, 10'h000, 0);
    step(0, 0, 0, 10'h000, 1);
    step(0, 0, 0, 10'h000, 1);
    check("ns_busy", 32'(bus.slip_busy), 1);
    step(0, 1, 3, 10'h007, 0);
    check("ns_fill2", 32'(bus.fill), 2);
    check("ns_busy0", 32'(bus.slip_busy), 0);

    // simultaneous slip and emit: buffer 0x556AB (19 bits) + 11b, then drop oldest
    step(1, 0, 0, 10'h000, 0);
    step(0, 1, 10, 10'h2AB, 0);
    step(0, 1, 9, 10'h155, 0);
    check("t5_fill19", 32'(bus.fill), 19);
    step(0, 1, 2, 10'h003, 1);
    check("t5_dout", 32'(bus.dout), 32'hEAB55);
    check("t5_vld1", 32'(bus.dout_vld), 1);
    check("t5_fill0", 32'(bus.fill), 0);
    check("t5_busy0", 32'(bus.slip_busy), 0);

    // reset mid-operation
    step(0, 1, 10, 10'h3FF, 0);
    step(0, 1, 5, 10'h01F, 0);
    check("t6_fill15", 32'(bus.fill), 15);
    step(0, 1, 13, 10'h000, 0);
    check("t6_err1", 32'(bus.err_samv), 1);
    step(1, 1, 10, 10'h3FF, 0);
    check("t6_fill", 32'(bus.fill), 0);
    check("t6_dout", 32'(bus.dout), 0);
    check("t6_vld", 32'(bus.dout_vld), 0);
    check("t6_err0", 32'(bus.err_samv), 0);
    step(0, 0, 0, 10'h000, 1);
    check("t6_busy1", 32'(bus.slip_busy), 1);
    step(1, 1, 10, 10'h3FF, 0);
    check("t6_busy0", 32'(bus.slip_busy), 0);
    check("t6_fill_b", 32'(bus.fill), 0);
    step(0, 1, 10, 10'h2AA, 0);
    step(0, 1, 10, 10'h2AA, 0);
    check("t6_dout_aa", 32'(bus.dout), 32'hAAAAA);
    check("t6_vld1", 32'(bus.dout_vld), 1);
    check("t6_fill0", 32'(bus.fill), 0);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
